// File: rtl/decoder_scan.sv
// Registered one-hot decoder with enable gate and programmable auto-scan.
// Scan index steps 0..last, dwelling div+1 enabled cycles per index.
module decoder_scan #(
    parameter int SEL_W      = 3,
    parameter int DIV_W      = 16,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      a,
    input  logic [SEL_W-1:0]      last,
    input  logic [DIV_W-1:0]      div,
    output logic [(2**SEL_W)-1:0] y,
    output logic [SEL_W-1:0]      idx,
    output logic                  tick,
    output logic                  wrap
);

    localparam int OUT_W = 2**SEL_W;
    localparam logic [OUT_W-1:0] IDLE = ACTIVE_LOW ? '1 : '0;

    logic [SEL_W-1:0] idx_q, idx_d;
    logic [DIV_W-1:0] pre_q, pre_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;
    logic [OUT_W-1:0] y_q, y_d;
    logic [OUT_W-1:0] hot;

    always_comb begin
        idx_d  = idx_q;
        pre_d  = pre_q;
        tick_d = 1'b0;
        wrap_d = 1'b0;
        hot    = '0;
        if (en) begin
            if (!mode) begin
                idx_d = a;
                pre_d = '0;
            end else if (pre_q != div) begin
                pre_d = pre_q + 1'b1;
            end else begin
                pre_d  = '0;
                tick_d = 1'b1;
                // >= so a live drop of last below idx still wraps
                if (idx_q >= last) begin
                    idx_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            hot = OUT_W'(1) << idx_d;
        end
        y_d = ACTIVE_LOW ? ~hot : hot;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= '0;
            pre_q  <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
            y_q    <= IDLE;
        end else begin
            idx_q  <= idx_d;
            pre_q  <= pre_d;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
            y_q    <= y_d;
        end
    end

    assign y    = y_q;
    assign idx  = idx_q;
    assign tick = tick_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Randomised and directed checks of decoder_scan against a behavioural model.
module tb_decoder_scan;

    logic        clk = 1'b0;
    logic        rst, en, mode;
    logic [2:0]  a, last;
    logic [15:0] div;
    logic [7:0]  y;
    logic [2:0]  idx;
    logic        tick, wrap;

    logic        rst2, en2;
    logic [3:0]  a2;
    logic [15:0] y2;
    logic [3:0]  idx2;
    logic        tick2, wrap2;

    int n_cmp = 0;
    int n_bad = 0;

    int m_idx, m_pre, m_y;
    bit m_tick, m_wrap;

    always #5 clk = ~clk;

    decoder_scan u_dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .a(a), .last(last), .div(div),
        .y(y), .idx(idx), .tick(tick), .wrap(wrap)
    );

    decoder_scan #(.SEL_W(4), .ACTIVE_LOW(1'b1)) u_dut_al (
        .clk(clk), .rst(rst2), .en(en2), .mode(1'b0),
        .a(a2), .last(4'd0), .div(16'd0),
        .y(y2), .idx(idx2), .tick(tick2), .wrap(wrap2)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Reference: dwell counted in enabled cycles, index wraps past last.
    task automatic model_edge();
        m_tick = 0;
        m_wrap = 0;
        if (rst) begin
            m_idx = 0;
            m_pre = 0;
            m_y   = 0;
        end else if (!en) begin
            m_y = 0;
        end else begin
            if (!mode) begin
                m_idx = int'(a);
                m_pre = 0;
            end else if (m_pre == int'(div)) begin
                m_pre  = 0;
                m_tick = 1;
                if (m_idx >= int'(last)) begin
                    m_idx  = 0;
                    m_wrap = 1;
                end else begin
                    m_idx = m_idx + 1;
                end
            end else begin
                m_pre = m_pre + 1;
            end
            m_y = 1 << m_idx;
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk({tag, ".y"},    32'(y),    32'(m_y));
        chk({tag, ".idx"},  32'(idx),  32'(m_idx));
        chk({tag, ".tick"}, 32'(tick), 32'(m_tick));
        chk({tag, ".wrap"}, 32'(wrap), 32'(m_wrap));
    endtask

    int nt, nw;

    initial begin
        rst = 1; en = 0; mode = 0; a = 0; last = 7; div = 0;
        rst2 = 1; en2 = 0; a2 = 0;
        m_idx = 0; m_pre = 0; m_y = 0; m_tick = 0; m_wrap = 0;

        step("rst");
        step("rst");
        chk("al.rst.y", 32'(y2), 32'hFFFF);
        rst = 0; rst2 = 0;

        en = 1;
        for (int i = 0; i < 8; i++) begin
            a = 3'(i);
            step("direct");
            chk("direct.hot", 32'(y), 32'(1 << i));
        end

        a = 5;
        step("gate.on");
        chk("gate.y20", 32'(y), 32'h20);
        en = 0;
        for (int i = 0; i < 3; i++) begin
            step("gate.off");
            chk("gate.hold", 32'(idx), 32'd5);
        end

        en = 1; mode = 0; a = 0;
        step("scan.pre");
        mode = 1; div = 2; last = 7;
        nt = 0; nw = 0;
        for (int i = 0; i < 24; i++) begin
            step("scan");
            nt += int'(tick);
            nw += int'(wrap);
        end
        chk("scan.ticks", 32'(nt), 32'd8);
        chk("scan.wraps", 32'(nw), 32'd1);

        mode = 0; a = 6;
        step("live.pre");
        mode = 1; div = 0; last = 3;
        step("live.wrap");
        chk("live.wrap1", 32'(wrap), 32'd1);
        for (int i = 0; i < 5; i++) step("live.loop");
        last = 0;
        for (int i = 0; i < 4; i++) begin
            step("last0");
            chk("last0.y", 32'(y), 32'h01);
        end

        mode = 0; a = 5;
        step("mid.pre");
        mode = 1; div = 4; last = 7;
        step("mid.d1");
        step("mid.d2");
        rst = 1;
        step("mid.rst");
        chk("mid.rst.y", 32'(y), 32'd0);
        rst = 0;
        for (int i = 0; i < 5; i++) step("mid.resume");
        chk("mid.adv", 32'(idx), 32'd1);

        en2 = 1; a2 = 9;
        @(posedge clk); #1;
        chk("al.a9", 32'(y2), 32'hFDFF);
        chk("al.idx", 32'(idx2), 32'd9);
        en2 = 0;
        @(posedge clk); #1;
        chk("al.off", 32'(y2), 32'hFFFF);
        m_y = 0;
        m_tick = 0;
        m_wrap = 0;
        // Keep the model aligned with the two extra edges above.
        en = 0; rst = 1;
        step("resync");
        rst = 0;

        for (int i = 0; i < 400; i++) begin
            rst  = ($urandom_range(0, 59) == 0);
            en   = ($urandom_range(0, 7) != 0);
            mode = ($urandom_range(0, 9) != 0);
            a    = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) last = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) div = 16'($urandom_range(0, 3));
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
